// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg
//   Shared constants, the IO write FIFO entry layout and small decode helpers
//   for the cpu-side memory/IO bridge.
//   Contents:
//     IO_ADDR_HI     address bits [17:16] value that selects the IO space
//     IO_PORT_UART   IO offset of the UART data port
//     IO_FIFO_W      width of one queued IO write (3-bit offset + 8-bit data)
//     io_wr_t        packed layout of one queued IO write
//     is_io_addr     true when a cpu address falls in the IO space
//     is_null_uart   true for a 0x00 write to the UART port, which is discarded
package mem_io_bridge_pkg;

  localparam logic [1:0] IO_ADDR_HI   = 2'b11;
  localparam logic [2:0] IO_PORT_UART = 3'h0;
  localparam int         IO_FIFO_W    = 11;

  typedef struct packed {
    logic [2:0] port;
    logic [7:0] data;
  } io_wr_t;

  function automatic logic is_io_addr(input logic [1:0] addr_hi);
    return (addr_hi == IO_ADDR_HI);
  endfunction

  // The UART treats a 0x00 byte on its data port as a no-op, so it never
  // needs to occupy a FIFO slot.
  function automatic logic is_null_uart(input logic [2:0] port, input logic [7:0] data);
    return (port == IO_PORT_UART) && (data == 8'h00);
  endfunction

endpackage

// File: rtl/mem_io_bridge_io_wr_fifo.sv
// io_wr_fifo
//   Synchronous FIFO that holds IO writes until the IO side can take them.
//   Pointers carry an extra wrap bit so full and empty are distinguishable
//   without a separate counter.
//   Ports:
//     clk_in     system clock
//     rst_n_in   asynchronous active-low reset (empties the FIFO)
//     push       write push_data at the tail (ignored when full)
//     push_data  entry to store
//     pop        discard the head entry (ignored when empty)
//     full       all DEPTH entries occupied
//     empty      no entries occupied
//     head       oldest entry (valid when ~empty)
module io_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Status flags, head read and next-state for pointers and storage.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
              (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    head    = mem_q[rd_ptr_q[IDX_W-1:0]];
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + {{IDX_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{IDX_W{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= {(IDX_W + 1){1'b0}};
      rd_ptr_q <= {(IDX_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Sits between the cpu memory bus and the RAM / UART-IO blocks. Each byte
//   access is decoded to RAM or IO (address bits [17:16] == 2'b11 is IO).
//   IO writes are queued in a small FIFO so UART back-pressure only stalls the
//   cpu once the FIFO is full; IO reads wait until every queued write is out.
//   Read data is returned exactly one cycle after the read is accepted.
//   Ports:
//     clk_in, rst_n_in   clock, asynchronous active-low reset
//     rdy_in             global ready; all state frozen while low
//     cpu_mem_a/_wr/_dout cpu bus (address, write flag, write data)
//     cpu_mem_din        read data to cpu
//     cpu_rdy_out        access accepted this cycle (rdy_in & ~stall)
//     ram_a/_wr/_din     RAM address, write enable, write data
//     ram_dout           RAM read data (1-cycle synchronous)
//     io_en/_wr/_a/_dout IO strobe, write flag, port offset, write data
//     io_din             IO read data (1-cycle)
//     io_buffer_full     UART tx buffer full; blocks draining the FIFO
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int IO_FIFO_DEPTH = 8,
  parameter int RAM_ADDR_W    = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic [31:0]           cpu_mem_a,
  input  logic                  cpu_mem_wr,
  input  logic [7:0]            cpu_mem_dout,
  output logic [7:0]            cpu_mem_din,
  output logic                  cpu_rdy_out,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout,
  output logic                  io_en,
  output logic                  io_wr,
  output logic [2:0]            io_a,
  output logic [7:0]            io_dout,
  input  logic [7:0]            io_din,
  input  logic                  io_buffer_full
);

  logic   is_io;
  logic   stall;
  logic   accept;
  logic   io_rd;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_full;
  logic   fifo_empty;
  io_wr_t fifo_push_data;
  io_wr_t fifo_head;
  logic   sel_io_q, sel_io_d;
  logic   unused_addr_bits;

  assign unused_addr_bits = ^cpu_mem_a[31:18];

  io_wr_fifo #(
    .DEPTH (IO_FIFO_DEPTH),
    .WIDTH (IO_FIFO_W)
  ) u_io_wr_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Decode, stall, accept and FIFO control. Everything is qualified by
  // rst_n_in so the bus-facing outputs read as idle while reset is held.
  always_comb begin
    is_io               = is_io_addr(cpu_mem_a[17:16]);
    fifo_push_data.port = cpu_mem_a[2:0];
    fifo_push_data.data = cpu_mem_dout;
    // A full FIFO stalls a write even if a pop happens this cycle; a read
    // waits until every queued write has gone out.
    stall  = is_io & ((cpu_mem_wr & fifo_full) | (~cpu_mem_wr & ~fifo_empty));
    accept = rst_n_in & rdy_in & ~stall;
    io_rd  = accept & is_io & ~cpu_mem_wr;
    fifo_push = accept & is_io & cpu_mem_wr &
                ~is_null_uart(cpu_mem_a[2:0], cpu_mem_dout);
    fifo_pop  = rst_n_in & rdy_in & ~fifo_empty & ~io_buffer_full;
    if (accept & ~cpu_mem_wr) begin
      sel_io_d = is_io;
    end else begin
      sel_io_d = sel_io_q;
    end
  end

  // cpu-facing and RAM-facing outputs.
  always_comb begin
    cpu_rdy_out = accept;
    ram_wr      = accept & ~is_io & cpu_mem_wr;
    if (rst_n_in) begin
      ram_a       = cpu_mem_a[RAM_ADDR_W-1:0];
      ram_din     = cpu_mem_dout;
      cpu_mem_din = sel_io_q ? io_din : ram_dout;
    end else begin
      ram_a       = {RAM_ADDR_W{1'b0}};
      ram_din     = 8'h00;
      cpu_mem_din = 8'h00;
    end
  end

  // IO bus: a drain and an IO read can never coincide because a read is
  // only accepted with the FIFO empty.
  always_comb begin
    if (fifo_pop) begin
      io_en   = 1'b1;
      io_wr   = 1'b1;
      io_a    = fifo_head.port;
      io_dout = fifo_head.data;
    end else if (io_rd) begin
      io_en   = 1'b1;
      io_wr   = 1'b0;
      io_a    = cpu_mem_a[2:0];
      io_dout = 8'h00;
    end else begin
      io_en   = 1'b0;
      io_wr   = 1'b0;
      io_a    = 3'h0;
      io_dout = 8'h00;
    end
  end

  // Remembers which source the last accepted read targeted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sel_io_q <= 1'b0;
    end else begin
      sel_io_q <= sel_io_d;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge
//   Directed scoreboard bench for mem_io_bridge. Stimulus pushes expected RAM
//   writes, IO bus transactions and read data into queues; a monitor on the
//   falling edge pops and compares whenever the DUT presents one of them.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] a;
  logic        wr;
  logic [7:0]  dout;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'hEE;
  logic        io_en;
  logic        io_wr;
  logic [2:0]  io_a;
  logic [7:0]  io_dout;
  logic [7:0]  io_din = 8'h00;
  logic        full;

  logic        rd_req = 1'b0;
  logic        rd_arm = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  ram_mem [1024];
  logic [11:0] io_q [$];
  logic [7:0]  rd_q [$];
  logic [24:0] ram_q [$];
  int          io_ev_cyc [$];

  mem_io_bridge dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .cpu_mem_a      (a),
    .cpu_mem_wr     (wr),
    .cpu_mem_dout   (dout),
    .cpu_mem_din    (cpu_din),
    .cpu_rdy_out    (cpu_rdy),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .io_en          (io_en),
    .io_wr          (io_wr),
    .io_a           (io_a),
    .io_dout        (io_dout),
    .io_din         (io_din),
    .io_buffer_full (full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 1-cycle synchronous read, write on ram_wr.
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a[9:0]] <= ram_din;
    ram_dout <= ram_mem[ram_a[9:0]];
  end

  // IO model: a read of offset n returns 0x31 + n one cycle later.
  always @(posedge clk) begin
    if (io_en && !io_wr) io_din <= 8'(8'h31 + {5'b0, io_a});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_arm = 1'b0;
    end else begin
      if (rd_arm) begin
        if (rd_q.size() == 0) chk("rd_unexpected", {24'h0, cpu_din}, 32'hFFFF_FFFF);
        else chk("rd_data", {24'h0, cpu_din}, {24'h0, rd_q.pop_front()});
      end
      rd_arm = rd_req && cpu_rdy;
      if (ram_wr) begin
        if (ram_q.size() == 0) chk("ram_wr_unexpected", {7'h0, ram_a, ram_din}, 32'hFFFF_FFFF);
        else chk("ram_wr", {7'h0, ram_a, ram_din}, {7'h0, ram_q.pop_front()});
      end
      if (io_en) begin
        io_ev_cyc.push_back(cyc);
        if (io_q.size() == 0) chk("io_unexpected", {20'h0, io_wr, io_a, io_dout}, 32'hFFFF_FFFF);
        else chk("io_bus", {20'h0, io_wr, io_a, io_wr ? io_dout : 8'h00}, {20'h0, io_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    a = 32'h0; wr = 1'b0; dout = 8'h00; rd_req = 1'b0;
  endtask

  // Presents one access and returns 1 time unit after the posedge that took it.
  task automatic cpu_access(input logic [31:0] addr, input logic w, input logic [7:0] d);
    int n = 0;
    a = addr; wr = w; dout = d; rd_req = !w;
    @(negedge clk);
    while (!cpu_rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_rdy) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int r;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 8'h00;
    rst_n = 1'b0; rdy = 1'b1; full = 1'b0;
    a = 32'h0003_0123; wr = 1'b1; dout = 8'h5A;
    #2;
    chk("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
    chk("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h0);
    chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("rst_ram_a", {15'h0, ram_a}, 32'h0);
    chk("rst_io_en", {31'h0, io_en}, 32'h0);
    chk("rst_io_wr", {31'h0, io_wr}, 32'h0);
    chk("rst_io_a", {29'h0, io_a}, 32'h0);
    chk("rst_io_dout", {24'h0, io_dout}, 32'h0);
    idle();
    step(2);
    rst_n = 1'b1;
    step(1);

    // RAM write then read-back, plus an untouched location.
    ram_q.push_back({17'h00100, 8'h55});
    cpu_access(32'h0000_0100, 1'b1, 8'h55);
    rd_q.push_back(8'h55);
    cpu_access(32'h0000_0100, 1'b0, 8'h00);
    ram_q.push_back({17'h00101, 8'hAA});
    cpu_access(32'h0000_0101, 1'b1, 8'hAA);
    rd_q.push_back(8'hAA);
    cpu_access(32'h0000_0101, 1'b0, 8'h00);
    rd_q.push_back(8'h00);
    cpu_access(32'h0000_0200, 1'b0, 8'h00);
    idle();
    step(3);

    // Three IO writes drain on consecutive cycles starting one after the first push.
    io_ev_cyc.delete();
    c0 = 0;
    for (int i = 0; i < 3; i++) begin
      io_q.push_back({1'b1, 3'h0, 8'(8'h41 + i)});
      cpu_access(32'h0003_0000, 1'b1, 8'(8'h41 + i));
      if (i == 0) c0 = cyc;
    end
    idle();
    step(4);
    chk("abc_count", io_ev_cyc.size(), 3);
    for (int i = 0; i < 3; i++) chk("abc_timing", io_ev_cyc[i], c0 + i);

    // Blocked UART: 8 writes fill the FIFO, the 9th stalls until the first pop.
    full = 1'b1;
    for (int i = 0; i < 9; i++) io_q.push_back({1'b1, 3'h1, 8'(8'h60 + i)});
    for (int i = 0; i < 8; i++) cpu_access(32'h0003_0001, 1'b1, 8'(8'h60 + i));
    a = 32'h0003_0001; wr = 1'b1; dout = 8'h68;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", {31'h0, cpu_rdy}, 32'h0);
      chk("full_no_drain", {31'h0, io_en}, 32'h0);
    end
    @(posedge clk);
    #1;
    io_ev_cyc.delete();
    full = 1'b0;
    r = cyc;
    cpu_access(32'h0003_0001, 1'b1, 8'h68);
    chk("ninth_accept_cyc", cyc, r + 2);
    idle();
    step(12);
    chk("full_drain_count", io_ev_cyc.size(), 9);
    chk("full_first_drain", io_ev_cyc[0], r);

    // IO read ordered behind two pending writes.
    full = 1'b1;
    io_q.push_back({1'b1, 3'h2, 8'h70});
    io_q.push_back({1'b1, 3'h2, 8'h71});
    cpu_access(32'h0003_0002, 1'b1, 8'h70);
    cpu_access(32'h0003_0002, 1'b1, 8'h71);
    a = 32'h0003_0000; wr = 1'b0; dout = 8'h00; rd_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rd_wait_stall", {31'h0, cpu_rdy}, 32'h0);
    end
    @(posedge clk);
    #1;
    io_ev_cyc.delete();
    io_q.push_back({1'b0, 3'h0, 8'h00});
    rd_q.push_back(8'h31);
    full = 1'b0;
    r = cyc;
    cpu_access(32'h0003_0000, 1'b0, 8'h00);
    idle();
    step(3);
    chk("rd_order_count", io_ev_cyc.size(), 3);
    chk("rd_after_drain", io_ev_cyc[2], r + 2);

    // Null UART write is dropped; offset-4 write goes through.
    io_ev_cyc.delete();
    cpu_access(32'h0003_0000, 1'b1, 8'h00);
    io_q.push_back({1'b1, 3'h4, 8'h01});
    cpu_access(32'h0003_0004, 1'b1, 8'h01);
    idle();
    step(4);
    chk("drop_count", io_ev_cyc.size(), 1);

    // Reset with four pending writes discards them.
    full = 1'b1;
    for (int i = 0; i < 4; i++) cpu_access(32'h0003_0003, 1'b1, 8'(8'h80 + i));
    idle();
    step(1);
    rst_n = 1'b0;
    io_q.delete();
    #2;
    chk("mid_rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h0);
    chk("mid_rst_io_en", {31'h0, io_en}, 32'h0);
    step(2);
    rst_n = 1'b1;
    full = 1'b0;
    io_ev_cyc.delete();
    step(10);
    chk("rst_discard", io_ev_cyc.size(), 0);

    // rdy_in low mid-drain freezes pops and pointers.
    full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_q.push_back({1'b1, 3'h5, 8'(8'h90 + i)});
      cpu_access(32'h0003_0005, 1'b1, 8'(8'h90 + i));
    end
    idle();
    io_ev_cyc.delete();
    full = 1'b0;
    step(2);
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("freeze_io_en", {31'h0, io_en}, 32'h0);
      chk("freeze_cpu_rdy", {31'h0, cpu_rdy}, 32'h0);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    step(4);
    chk("freeze_count", io_ev_cyc.size(), 4);
    chk("freeze_gap", io_ev_cyc[2], io_ev_cyc[1] + 6);

    step(3);
    chk("io_q_empty", io_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("ram_q_empty", ram_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
